// File: rtl/kitt_tail_fader_pkg.sv
// Shared definitions for the KITT tail fader: default sizes, level type and
// the saturating decay subtract used by every LED cell.
package kitt_pkg;

    localparam int N_LEDS_DEF = 8;
    localparam int LVL_W_DEF  = 4;
    localparam int MAX_LVL    = (1 << LVL_W_DEF) - 1;

    typedef logic [LVL_W_DEF-1:0] lvl_t;

    // One extra bit catches the borrow so the level clamps at 0 instead of wrapping.
    function automatic lvl_t sat_sub(lvl_t a, lvl_t d);
        logic [LVL_W_DEF:0] diff;
        diff = {1'b0, a} - {1'b0, d};
        return diff[LVL_W_DEF] ? '0 : diff[LVL_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/kitt_tail_fader_fade_cell.sv
// One LED channel: brightness level register with head-load / decay and the
// PWM comparator against the shared counter.
module kitt_fade_cell
    import kitt_pkg::*;
#(
    parameter int DECAY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic step,
    input  logic head,
    input  lvl_t pwm_cnt,
    output logic pwm_bit,
    output logic nonzero
);

    localparam lvl_t DECAY_L = lvl_t'(DECAY);

    lvl_t level_q, level_d;
    logic pwm_q, pwm_d;

    always_comb begin
        level_d = level_q;
        if (ena && step) begin
            level_d = head ? lvl_t'(MAX_LVL) : sat_sub(level_q, DECAY_L);
        end
        pwm_d = ena & (level_q > pwm_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_bit = pwm_q;
    assign nonzero = |level_q;

endmodule

// File: rtl/kitt_tail_fader.sv
// LED stage of the KITT scanner: per-LED fading levels rendered through a
// shared free-running PWM counter.
module kitt_tail_fader
    import kitt_pkg::*;
#(
    parameter int N_LEDS = N_LEDS_DEF,
    parameter int LVL_W  = LVL_W_DEF,
    parameter int DECAY  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [N_LEDS-1:0] pos_onehot,
    input  logic              step,
    output logic [N_LEDS-1:0] led_pwm,
    output logic              tail_active
);

    // Level type and subtract helper live in the package, so the width is pinned there.
    if (LVL_W != LVL_W_DEF) begin : g_bad_lvl_w
        $error("kitt_tail_fader: LVL_W must equal kitt_pkg::LVL_W_DEF");
    end
    if (DECAY < 1 || DECAY > MAX_LVL) begin : g_bad_decay
        $error("kitt_tail_fader: DECAY must be in 1..MAX_LVL");
    end

    lvl_t              pwm_cnt_q, pwm_cnt_d;
    logic              tail_active_q, tail_active_d;
    logic [N_LEDS-1:0] nonzero;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        if (ena) begin
            pwm_cnt_d = (pwm_cnt_q == lvl_t'(MAX_LVL - 1)) ? '0 : pwm_cnt_q + lvl_t'(1);
        end
        tail_active_d = |nonzero;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q     <= '0;
            tail_active_q <= 1'b0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            tail_active_q <= tail_active_d;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_cell
        kitt_fade_cell #(
            .DECAY(DECAY)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .ena    (ena),
            .step   (step),
            .head   (pos_onehot[i]),
            .pwm_cnt(pwm_cnt_q),
            .pwm_bit(led_pwm[i]),
            .nonzero(nonzero[i])
        );
    end

    assign tail_active = tail_active_q;

endmodule

// File: tb/tb_kitt_tail_fader.sv
// Scoreboard bench for kitt_tail_fader: a level/duty-cycle model predicts the
// outputs after every clock edge and a negedge monitor compares them.
module tb_kitt_tail_fader;

    localparam int N   = 8;
    localparam int MAX = 15;
    localparam int DEC = 3;

    typedef struct {
        logic [N-1:0] led;
        logic         tail;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         ena;
    logic [N-1:0] pos_onehot;
    logic         step;
    logic [N-1:0] led_pwm;
    logic         tail_active;

    exp_t exp_q[$];
    int   lvl[N];
    int   pwm_phase;
    int   n_pass;
    int   n_total;

    kitt_tail_fader #(
        .N_LEDS(N),
        .LVL_W (4),
        .DECAY (DEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .pos_onehot (pos_onehot),
        .step       (step),
        .led_pwm    (led_pwm),
        .tail_active(tail_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) lvl[i] = 0;
        pwm_phase = 0;
    endtask

    // Outputs after an edge depend on the state before it; then the state advances.
    task automatic model_edge();
        exp_t e;
        e.led  = '0;
        e.tail = 1'b0;
        if (rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < N; i++) begin
                e.led[i] = ena && (lvl[i] > pwm_phase);
                if (lvl[i] != 0) e.tail = 1'b1;
            end
            if (ena) begin
                if (step) begin
                    for (int i = 0; i < N; i++) begin
                        if (pos_onehot[i]) lvl[i] = MAX;
                        else               lvl[i] = (lvl[i] > DEC) ? lvl[i] - DEC : 0;
                    end
                end
                pwm_phase = (pwm_phase + 1) % MAX;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic e, input logic s, input logic [N-1:0] p);
        ena        = e;
        step       = s;
        pos_onehot = p;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) applyStimulus(1'b1, 1'b0, '0);
    endtask

    task automatic mid_run_reset();
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_led", int'(led_pwm), 0);
        checkOutput("async_rst_tail", int'(tail_active), 0);
        exp_q.delete();
        model_clear();
        applyStimulus(1'b1, 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b0, '0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("led_pwm", int'(led_pwm), int'(e.led));
            checkOutput("tail_active", int'(tail_active), int'(e.tail));
        end
    end

    initial begin
        int on_cnt;
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        ena        = 1'b0;
        step       = 1'b0;
        pos_onehot = '0;
        model_clear();
        #1;
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 8'hFF);
        rst = 1'b0;
        idle(20);

        $display("[TB] single head");
        applyStimulus(1'b1, 1'b1, 8'h01);
        idle(30);

        $display("[TB] decay tail");
        applyStimulus(1'b1, 1'b1, 8'h01);
        applyStimulus(1'b1, 1'b1, 8'h02);
        applyStimulus(1'b1, 1'b1, 8'h04);
        applyStimulus(1'b1, 1'b1, 8'h08);
        idle(1);
        on_cnt = 0;
        for (int c = 0; c < MAX; c++) begin
            idle(1);
            on_cnt += int'(led_pwm[0]);
        end
        checkOutput("duty_led0", on_cnt, 6);
        on_cnt = 0;
        for (int c = 0; c < MAX; c++) begin
            idle(1);
            on_cnt += int'(led_pwm[2]);
        end
        checkOutput("duty_led2", on_cnt, 12);
        for (int s = 0; s < 3; s++) applyStimulus(1'b1, 1'b1, '0);
        checkOutput("model_led0_sat", lvl[0], 0);
        idle(16);

        $display("[TB] full fade-out");
        for (int s = 0; s < 5; s++) applyStimulus(1'b1, 1'b1, '0);
        idle(5);

        $display("[TB] ena gating");
        applyStimulus(1'b1, 1'b1, 8'h80);
        applyStimulus(1'b1, 1'b1, 8'h40);
        idle(7);
        for (int c = 0; c < 10; c++) applyStimulus(1'b0, c[0], 8'h80);
        idle(20);

        $display("[TB] multi-hot");
        applyStimulus(1'b1, 1'b1, 8'h81);
        idle(20);

        mid_run_reset();
        idle(20);

        $display("[TB] random");
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] p;
            if ($urandom_range(3) == 0) p = N'($urandom);
            else                        p = N'(1) << $urandom_range(N - 1);
            applyStimulus(($urandom_range(9) != 0), ($urandom_range(3) == 0), p);
            if (c == 300) mid_run_reset();
        end

        @(negedge clk);
        #1;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
